// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single GPR write port, shared by the ALU (req0) and the LSU (req1).
// Also tracks a per-register busy scoreboard that the issue stage uses to stall on RAW hazards.
module rf_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              stall,
    output logic              rd_we,
    output logic [ADDR_W-1:0] rd_waddr,
    output logic [DATA_W-1:0] rd_wdata,
    output logic [NREG-1:0]   busy_vec
);

    logic              prio_q, prio_d;  // 0: req0 wins a tie, 1: req1 wins a tie
    logic              rd_we_q, rd_we_d;
    logic [ADDR_W-1:0] rd_waddr_q, rd_waddr_d;
    logic [DATA_W-1:0] rd_wdata_q, rd_wdata_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              grant0, grant1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A busy source is safe once its write is presenting: the GPR file writes through.
    function automatic logic src_stall(input logic [ADDR_W-1:0] s,
                                       input logic [NREG-1:0]   busy,
                                       input logic              we,
                                       input logic [ADDR_W-1:0] waddr);
        return (s != '0) && busy[s] && !(we && (waddr == s));
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        grant0     = req0_valid && (!req1_valid || !prio_q);
        grant1     = req1_valid && (!req0_valid ||  prio_q);
        prio_d     = (req0_valid && req1_valid) ? !prio_q : prio_q;
        sel_addr   = grant1 ? req1_addr : req0_addr;
        sel_data   = grant1 ? req1_data : req0_data;

        // x0 beats are consumed but never reach the register file.
        rd_we_d    = (grant0 || grant1) && (sel_addr != '0);
        rd_waddr_d = rd_we_d ? sel_addr : rd_waddr_q;
        rd_wdata_d = rd_we_d ? sel_data : rd_wdata_q;

        // Set after clear, so a new producer of the same register keeps it busy.
        busy_d = busy_q;
        if (rd_we_q) begin
            busy_d[rd_waddr_q] = 1'b0;
        end
        if (alloc_valid && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q     <= 1'b0;
            rd_we_q    <= 1'b0;
            rd_waddr_q <= '0;
            rd_wdata_q <= '0;
            // NOTE: the scoreboard is a flop vector, not a RAM, so it can and must be reset.
            busy_q     <= '0;
        end else begin
            prio_q     <= prio_d;
            rd_we_q    <= rd_we_d;
            rd_waddr_q <= rd_waddr_d;
            rd_wdata_q <= rd_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign stall      = src_stall(rs1_addr, busy_q, rd_we_q, rd_waddr_q) ||
                        src_stall(rs2_addr, busy_q, rd_we_q, rd_waddr_q);
    assign rd_we      = rd_we_q;
    assign rd_waddr   = rd_waddr_q;
    assign rd_wdata   = rd_wdata_q;
    assign busy_vec   = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a cycle model predicts grants, stall and busy state,
// and queues the expected writeback beat that is compared one edge later.
module tb_rf_wb_arbiter;

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_data = '0, req1_data = '0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_addr = '0, rs1_addr = '0, rs2_addr = '0;
    logic        stall, rd_we;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic [31:0] busy_vec;

    int total = 0;
    int bad   = 0;

    wb_t         scb[$];
    logic        m_prio = 1'b0;
    logic [31:0] m_busy = '0;
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic        m_g0 = 1'b0, m_g1 = 1'b0;

    rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    always @(posedge rst) begin
        scb.delete();
        m_prio = 1'b0;
        m_busy = '0;
        m_we   = 1'b0;
        m_waddr = '0;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
    end

    // Mid-cycle: check combinational outputs against the model, then advance the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic        g0, g1, exp_stall, nwe;
            logic [31:0] nb;
            logic [4:0]  sa;
            logic [31:0] sd;
            g0 = req0_valid && (!req1_valid || !m_prio);
            g1 = req1_valid && (!req0_valid ||  m_prio);
            exp_stall = ((rs1_addr != 0) && m_busy[rs1_addr] && !(m_we && m_waddr == rs1_addr)) ||
                        ((rs2_addr != 0) && m_busy[rs2_addr] && !(m_we && m_waddr == rs2_addr));
            total += 4;
            if (req0_ready !== g0) begin
                bad++; $display("FAIL req0_ready: got %b want %b at %0t", req0_ready, g0, $time);
            end
            if (req1_ready !== g1) begin
                bad++; $display("FAIL req1_ready: got %b want %b at %0t", req1_ready, g1, $time);
            end
            if (stall !== exp_stall) begin
                bad++; $display("FAIL stall: got %b want %b at %0t", stall, exp_stall, $time);
            end
            if (busy_vec !== m_busy) begin
                bad++; $display("FAIL busy_vec: got %h want %h at %0t", busy_vec, m_busy, $time);
            end
            nb = m_busy;
            if (m_we) nb[m_waddr] = 1'b0;
            if (alloc_valid && alloc_addr != 0) nb[alloc_addr] = 1'b1;
            nb[0] = 1'b0;
            if (req0_valid && req1_valid) m_prio = !m_prio;
            sa  = g1 ? req1_addr : req0_addr;
            sd  = g1 ? req1_data : req0_data;
            nwe = (g0 || g1) && (sa != 0);
            scb.push_back('{we: nwe, addr: sa, data: sd});
            m_we = nwe;
            if (nwe) m_waddr = sa;
            m_busy = nb;
            m_g0 = g0;
            m_g1 = g1;
        end
    end

    // Just after each edge: the registered write port must show the queued beat.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            wb_t e;
            total++;
            if (scb.size() == 0) begin
                if (rd_we !== 1'b0) begin
                    bad++; $display("FAIL wb_port: rd_we=%b with nothing expected at %0t", rd_we, $time);
                end
            end else begin
                e = scb.pop_front();
                if (rd_we !== e.we || (e.we && (rd_waddr !== e.addr || rd_wdata !== e.data))) begin
                    bad++;
                    $display("FAIL wb_port: got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h at %0t",
                             rd_we, rd_waddr, rd_wdata, e.we, e.addr, e.data, $time);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        req0_valid  = 1'b0;
        req1_valid  = 1'b0;
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) next();
        total += 2;
        if (rd_we !== 1'b0 || rd_waddr !== 5'd0 || rd_wdata !== 32'd0) begin
            bad++; $display("FAIL reset_outputs: got we=%b addr=%0d data=%h want 0/0/0", rd_we, rd_waddr, rd_wdata);
        end
        if (busy_vec !== 32'd0) begin
            bad++; $display("FAIL reset_busy: got %h want 0", busy_vec);
        end
        rst = 1'b0;
        next();
        alloc_valid = 1'b1; alloc_addr = 5'd10;
        next();
        alloc_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0001;
        next();
        idle();
        total++;
        if (rd_we !== 1'b1 || busy_vec !== 32'h0000_0400) begin
            bad++; $display("FAIL reset_setup: got we=%b busy=%h want 1/00000400", rd_we, busy_vec);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (rd_we !== 1'b0 || busy_vec !== 32'd0) begin
            bad++; $display("FAIL reset_async: got we=%b busy=%h want 0/0", rd_we, busy_vec);
        end
        next();
        rst = 1'b0;
        next();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hDEAD_BEEF;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
        end
        next();
        idle();
        total++;
        if (rd_we !== 1'b1 || rd_waddr !== 5'd10 || rd_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single_write: got we=%b addr=%0d data=%h want 1/10/deadbeef", rd_we, rd_waddr, rd_wdata);
        end
        next();
        total++;
        if (rd_we !== 1'b0) begin
            bad++; $display("FAIL single_pulse: got rd_we=%b want 0", rd_we);
        end
    endtask

    task automatic test_contention();
        logic       exp0;
        logic [1:0] want [7] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        logic [1:0] vld  [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11};
        req0_addr = 5'd11; req0_data = 32'h1111_0000;
        req1_addr = 5'd12; req1_data = 32'h2222_0000;
        // Tie, tie, tie, tie, lone req0, tie, tie: the lone beat must not move the pointer.
        for (int i = 0; i < 7; i++) begin
            req0_valid = vld[i][1];
            req1_valid = vld[i][0];
            #1;
            total++;
            if ({req0_ready, req1_ready} !== want[i]) begin
                bad++; $display("FAIL contention_grant[%0d]: got %b%b want %b", i, req0_ready, req1_ready, want[i]);
            end
            exp0 = want[i][1];
            next();
            if (exp0) req0_data = req0_data + 1;
            else      req1_data = req1_data + 1;
        end
        req0_valid = 1'b0; req1_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL lone_req1: got %b%b want 01", req0_ready, req1_ready);
        end
        next();
        req0_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL after_lone_req1: got %b%b want 10", req0_ready, req1_ready);
        end
        next();
        idle();
        next();
    endtask

    task automatic test_x0();
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        next();
        alloc_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'd5;
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++; $display("FAIL x0_ready: got %b want 1", req1_ready);
        end
        next();
        idle();
        total++;
        if (rd_we !== 1'b0 || busy_vec !== 32'h0000_0200) begin
            bad++; $display("FAIL x0_write: got we=%b busy=%h want 0/00000200", rd_we, busy_vec);
        end
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9;
        next();
        idle();
        next();
    endtask

    task automatic test_scoreboard();
        alloc_valid = 1'b1; alloc_addr = 5'd5;
        next();
        alloc_valid = 1'b0;
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL stall_busy: got %b want 1", stall);
        end
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h5555_5555;
        next();
        idle();
        total++;
        if (rd_we !== 1'b1 || rd_waddr !== 5'd5 || stall !== 1'b0) begin
            bad++; $display("FAIL stall_writethrough: got we=%b addr=%0d stall=%b want 1/5/0", rd_we, rd_waddr, stall);
        end
        next();
        total++;
        if (busy_vec[5] !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL stall_cleared: got busy5=%b stall=%b want 0/0", busy_vec[5], stall);
        end
        alloc_valid = 1'b1; alloc_addr = 5'd6;
        next();
        alloc_valid = 1'b0;
        rs1_addr = 5'd0; rs2_addr = 5'd6;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL stall_rs2: got %b want 1", stall);
        end
        rs2_addr = 5'd0;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL stall_zero: got %b want 0", stall);
        end
        req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h6;
        next();
        idle();
        next();
    endtask

    task automatic test_collision();
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        next();
        alloc_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h7777_7777;
        next();
        req0_valid = 1'b0;
        alloc_valid = 1'b1; alloc_addr = 5'd7;
        next();
        alloc_valid = 1'b0;
        total++;
        if (busy_vec[7] !== 1'b1) begin
            bad++; $display("FAIL collision: got busy7=%b want 1", busy_vec[7]);
        end
        req0_valid = 1'b1;
        next();
        idle();
        next();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            if (!req0_valid || m_g0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_addr  = 5'($urandom_range(0, 31));
                req0_data  = $urandom;
            end
            if (!req1_valid || m_g1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_addr  = 5'($urandom_range(0, 31));
                req1_data  = $urandom;
            end
            alloc_valid = ($urandom_range(0, 1) != 0);
            alloc_addr  = 5'($urandom_range(0, 31));
            rs1_addr    = 5'($urandom_range(0, 31));
            rs2_addr    = 5'($urandom_range(0, 31));
            next();
        end
        idle();
        rs1_addr = '0; rs2_addr = '0;
        repeat (2) next();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_scoreboard();
        test_collision();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 32-entry GPR file between two writeback requesters: req0 (ALU/execute) and req1 (LSU/load).
- Keeps a per-register busy scoreboard so the issue stage can stall on RAW hazards against writes still in flight.
- Sits between the execute/memory stages and the GPR file's write port (we/waddr/wdata).

Parameters:
- DATA_W, 32, GPR data width.
- ADDR_W, 5, GPR address width.
- NREG, 32, number of GPRs; x0 is hardwired zero.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  request accepted this cycle.
- req0_addr  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write data.
- req1_valid  in  1  LSU writeback request.
- req1_ready  out  1  request accepted this cycle.
- req1_addr  in  ADDR_W  destination register.
- req1_data  in  DATA_W  write data.
- alloc_valid  in  1  issue stage dispatches an instruction that writes rd.
- alloc_addr  in  ADDR_W  rd of the dispatched instruction.
- rs1_addr  in  ADDR_W  issue-stage source 1.
- rs2_addr  in  ADDR_W  issue-stage source 2.
- stall  out  1  a source register is busy and not being written this cycle.
- rd_we  out  1  GPR write enable, registered.
- rd_waddr  out  ADDR_W  GPR write address, registered.
- rd_wdata  out  DATA_W  GPR write data, registered.
- busy_vec  out  NREG  scoreboard state, for debug.

Behaviour:
- Reset (async): rd_we=0, rd_waddr=0, rd_wdata=0, busy_vec=0, priority pointer = req0 first.
- Arbitration is combinational each cycle.
  - One requester valid: that requester gets ready=1.
  - Both valid: the requester named by the priority pointer wins; the loser sees ready=0 and must hold valid/addr/data stable.
- Priority pointer: 1-bit round-robin. It flips to the non-winner only on a cycle where both requesters are valid. A single-request grant leaves it unchanged.
- At most one ready is high per cycle. ready never depends on rd_we; the port accepts one write per cycle, always.
- Latency: an accepted request (valid&ready) appears on rd_we/rd_waddr/rd_wdata at the next posedge, held for exactly one cycle.
  - No acceptance: rd_we=0; rd_waddr/rd_wdata hold their previous values.
- Writes to x0: accepted (ready=1) and consumed, but rd_we stays 0 for that beat; the scoreboard is unaffected.
- Scoreboard, updated at posedge:
  - Set: alloc_valid && alloc_addr!=0 sets busy[alloc_addr].
  - Clear: rd_we=1 in the current cycle clears busy[rd_waddr].
  - Same register set and cleared in one cycle: set wins (newer producer).
  - busy[0] is always 0.
- stall, combinational, evaluated per source s in {rs1, rs2}:
  - s==0: no stall contribution.
  - s is busy and not (rd_we && rd_waddr==s): stall contribution. When that write is presenting, the GPR file's same-cycle write-through forwards the value, so no stall.
  - stall = OR of both contributions.
- An accepted write whose register is not busy is legal (e.g. an untracked CSR-read result) and is written normally.
- Reset mid-operation: any accepted-but-unwritten beat is discarded, rd_we drops immediately, and the scoreboard clears.

Test Plan:
- Reset: assert rst mid-cycle with busy_vec=0x0000_0400 and rd_we=1 -> rd_we=0 and busy_vec=0 asynchronously, with no posedge needed.
- Single write: req0 {addr=10, data=0xDEADBEEF} with only req0 valid -> req0_ready=1 the same cycle; next cycle rd_we=1, rd_waddr=10, rd_wdata=0xDEADBEEF; the cycle after, rd_we=0.
- Contention:
  - Both valid for 4 cycles after reset, each re-presenting a new request after acceptance -> grants alternate req0, req1, req0, req1; exactly one ready per cycle.
  - A lone req1 beat in between leaves the pointer unchanged.
- x0 write: req1 addr=0, data=5 -> req1_ready=1, rd_we stays 0, busy_vec unchanged.
- Scoreboard/stall:
  - alloc x5, then rs1=5 -> stall=1.
  - req0 addr=5 accepted -> on the rd_we cycle with rd_waddr=5, stall=0 (write-through), and busy[5]=0 afterwards.
  - rs2=0 never stalls.
- Set/clear collision: rd_we to x7 while alloc_addr=7 in the same cycle -> busy[7] remains 1.
